// File: rtl/rollo_ct_loader.sv
// rollo_ct_loader -- ciphertext ingest for the ROLLO-III decrypt datapath.
//
// Packs a stream of 32-bit ciphertext words into m*digit-bit rows. It writes
// all rows of sr into ct0, then all rows of se into ct1. The write ports read
// zero whenever no write is happening, so several masters can be OR-merged
// onto the same memory.
//
// Optional build macro:
//   CT_LOADER_PAD_CHECK_EN - when defined, a nonzero bit in the padding
//                            coefficient slots or in the discarded overflow of
//                            the last row of either half sets the sticky err
//                            flag. When undefined, padding is silently masked
//                            and err is tied to 0.
//
// Ports:
//   clk       in   1      single clock
//   rst_b     in   1      synchronous active-low reset
//   start     in   1      begin loading one ciphertext (sampled only in IDLE)
//   in_valid  in   1      in_data holds a word
//   in_data   in   32     ciphertext word
//   in_ready  out  1      word accepted when in_valid & in_ready
//   sr_addr   out  AW     ct0 row address (0 when sr_rw = 0)
//   sr_dout   out  ROW_W  ct0 write data (0 when sr_rw = 0)
//   sr_rw     out  1      ct0 write strobe, one cycle per row
//   se_addr   out  AW     ct1 row address (0 when se_rw = 0)
//   se_dout   out  ROW_W  ct1 write data (0 when se_rw = 0)
//   se_rw     out  1      ct1 write strobe, one cycle per row
//   done      out  1      one-cycle pulse after the final se row is written
//   err       out  1      padding violation flag

`ifndef N
`define N 5
`endif
`ifndef M
`define M 20
`endif
`ifndef DIGIT
`define DIGIT 2
`endif

module rollo_ct_loader #(
    parameter int  n     = `N,
    parameter int  m     = `M,
    parameter int  digit = `DIGIT,
    localparam int ROW_W = m * digit,
    localparam int ROWS  = n / digit + (((n % digit) != 0) ? 1 : 0),
    localparam int WPR   = (ROW_W + 31) / 32,
    localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [AW-1:0]    sr_addr,
    output logic [ROW_W-1:0] sr_dout,
    output logic             sr_rw,
    output logic [AW-1:0]    se_addr,
    output logic [ROW_W-1:0] se_dout,
    output logic             se_rw,
    output logic             done,
    output logic             err
);

    localparam int WW      = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int REM     = n % digit;
    localparam int VALID_W = (REM == 0) ? ROW_W : m * REM;
    localparam int BUF_W   = 32 * WPR;

    localparam logic [AW-1:0]    LAST_ROW  = AW'(ROWS - 1);
    localparam logic [WW-1:0]    LAST_WORD = WW'(WPR - 1);
    // Keeps only the real coefficient slots of the final row of a half.
    localparam logic [ROW_W-1:0] LAST_MASK = {ROW_W{1'b1}} >> (ROW_W - VALID_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_SR = 2'd1,
        LOAD_SE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    row_q, row_d;
    logic [WW-1:0]    word_q, word_d;
    logic [ROW_W-1:0] buf_q, buf_d;
    logic [AW-1:0]    sr_addr_q, sr_addr_d, se_addr_q, se_addr_d;
    logic [ROW_W-1:0] sr_dout_q, sr_dout_d, se_dout_q, se_dout_d;
    logic             sr_rw_q, sr_rw_d, se_rw_q, se_rw_d;
    logic             done_q, done_d;

    logic             last_word, last_row;
    logic [BUF_W-1:0] word_wide;
    logic [ROW_W-1:0] row_full, row_data;

    assign in_ready  = (state_q == LOAD_SR) || (state_q == LOAD_SE);
    assign last_word = (word_q == LAST_WORD);
    assign last_row  = (row_q == LAST_ROW);

    // The buffer is always clear above the current word, so OR-ing the
    // shifted word in is enough; bits shifted past ROW_W are dropped.
    assign word_wide = BUF_W'(in_data);
    assign row_full  = buf_q | ROW_W'(word_wide << {word_q, 5'b0});
    assign row_data  = last_row ? (row_full & LAST_MASK) : row_full;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        word_d    = word_q;
        buf_d     = buf_q;
        sr_addr_d = '0;
        sr_dout_d = '0;
        sr_rw_d   = 1'b0;
        se_addr_d = '0;
        se_dout_d = '0;
        se_rw_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_SR;
                    row_d   = '0;
                    word_d  = '0;
                    buf_d   = '0;
                end
            end
            LOAD_SR, LOAD_SE: begin
                if (in_valid) begin
                    if (last_word) begin
                        buf_d  = '0;
                        word_d = '0;
                        if (state_q == LOAD_SR) begin
                            sr_rw_d   = 1'b1;
                            sr_addr_d = row_q;
                            sr_dout_d = row_data;
                        end else begin
                            se_rw_d   = 1'b1;
                            se_addr_d = row_q;
                            se_dout_d = row_data;
                        end
                        if (last_row) begin
                            row_d   = '0;
                            state_d = (state_q == LOAD_SR) ? LOAD_SE : FINISH;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        buf_d  = row_full;
                        word_d = word_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                // The final se write is on the port this cycle.
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            row_q     <= '0;
            word_q    <= '0;
            buf_q     <= '0;
            sr_addr_q <= '0;
            sr_dout_q <= '0;
            sr_rw_q   <= 1'b0;
            se_addr_q <= '0;
            se_dout_q <= '0;
            se_rw_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            word_q    <= word_d;
            buf_q     <= buf_d;
            sr_addr_q <= sr_addr_d;
            sr_dout_q <= sr_dout_d;
            sr_rw_q   <= sr_rw_d;
            se_addr_q <= se_addr_d;
            se_dout_q <= se_dout_d;
            se_rw_q   <= se_rw_d;
            done_q    <= done_d;
        end
    end

    assign sr_addr = sr_addr_q;
    assign sr_dout = sr_dout_q;
    assign sr_rw   = sr_rw_q;
    assign se_addr = se_addr_q;
    assign se_dout = se_dout_q;
    assign se_rw   = se_rw_q;
    assign done    = done_q;

`ifdef CT_LOADER_PAD_CHECK_EN
    // Number of meaningful bits in the final word of a row.
    localparam int          LAST_BITS = ROW_W - 32 * (WPR - 1);
    localparam logic [31:0] KEEP_LAST = 32'hFFFF_FFFF >> (32 - LAST_BITS);

    logic err_q, err_d, pad_bad;

    always_comb begin
        pad_bad = (|(row_full & ~LAST_MASK)) || (|(in_data & ~KEEP_LAST));
        err_d   = err_q;
        if ((state_q == IDLE) && start) begin
            err_d = 1'b0;
        end else if (in_ready && in_valid && last_word && last_row && pad_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rollo_ct_loader.sv
module tb_rollo_ct_loader;

    localparam int N_P   = 5;
    localparam int M_P   = 20;
    localparam int D_P   = 2;
    localparam int ROW_W = M_P * D_P;
    localparam int ROWS  = 3;
    localparam int WPR   = 2;
    localparam int HW    = ROWS * WPR;
    localparam int NW    = 2 * HW;
`ifdef CT_LOADER_PAD_CHECK_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready;
    logic [1:0]       sr_addr, se_addr;
    logic [ROW_W-1:0] sr_dout, se_dout;
    logic             sr_rw, se_rw, done, err;

    int total = 0;
    int bad   = 0;
    int idle_viol = 0;
    int both_viol = 0;

    logic [1:0]       sr_a_log[$], se_a_log[$];
    logic [ROW_W-1:0] sr_d_log[$], se_d_log[$];
    logic [31:0]      stim[NW];

    typedef struct {
        int               row;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic [ROW_W-1:0] dout;
        bit               perr;
    } tv_t;
    tv_t tv[6];

    rollo_ct_loader #(.n(N_P), .m(M_P), .digit(D_P)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sr_addr  (sr_addr),
        .sr_dout  (sr_dout),
        .sr_rw    (sr_rw),
        .se_addr  (se_addr),
        .se_dout  (se_dout),
        .se_rw    (se_rw),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Memory-side observer: records every write, flags nonzero idle ports.
    always @(negedge clk) begin
        if (sr_rw) begin
            sr_a_log.push_back(sr_addr);
            sr_d_log.push_back(sr_dout);
        end else if (sr_addr != '0 || sr_dout != '0) begin
            idle_viol++;
        end
        if (se_rw) begin
            se_a_log.push_back(se_addr);
            se_d_log.push_back(se_dout);
        end else if (se_addr != '0 || se_dout != '0) begin
            idle_viol++;
        end
        if (sr_rw && se_rw) both_viol++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference row: the real coefficients of row r, each m bits, taken from
    // the little-endian word pair; padding slots and overflow contribute 0.
    function automatic logic [ROW_W-1:0] exp_row(input int half, input int r);
        logic [63:0]      w;
        logic [ROW_W-1:0] v;
        w = {stim[half*HW + r*WPR + 1], stim[half*HW + r*WPR]};
        v = '0;
        for (int s = 0; s < D_P; s++) begin
            if (r * D_P + s < N_P) v[s*M_P +: M_P] = w[s*M_P +: M_P];
        end
        return v;
    endfunction

    // Padding violation: last-row words carry any bit outside the real slots.
    function automatic bit half_err(input int half);
        logic [63:0] w;
        w = {stim[half*HW + (ROWS-1)*WPR + 1], stim[half*HW + (ROWS-1)*WPR]};
        return (w != 64'(exp_row(half, ROWS - 1)));
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_sr_rw"},    64'(sr_rw),    64'd0);
        chk({tag, "_se_rw"},    64'(se_rw),    64'd0);
        chk({tag, "_sr_addr"},  64'(sr_addr),  64'd0);
        chk({tag, "_sr_dout"},  64'(sr_dout),  64'd0);
        chk({tag, "_se_addr"},  64'(se_addr),  64'd0);
        chk({tag, "_se_dout"},  64'(se_dout),  64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
    endtask

    task automatic feed(input int nwords, input bit gaps, input int poke_at);
        int g;
        int guard;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            start    = (i == poke_at);
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 20) chk("in_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_full(input bit gaps, input int poke_at, input string tag);
        int sb, eb, iv, bv;
        sb = sr_a_log.size();
        eb = se_a_log.size();
        iv = idle_viol;
        bv = both_viol;
        feed(NW, gaps, poke_at);
        // One cycle after the final word: last se write on the port.
        chk({tag, "_se_rw_last"}, 64'(se_rw), 64'd1);
        chk({tag, "_done_early"}, 64'(done), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done"},     64'(done),     64'd1);
        chk({tag, "_ready_idle"}, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_sr_writes"}, 64'(sr_a_log.size() - sb), 64'(ROWS));
        chk({tag, "_se_writes"}, 64'(se_a_log.size() - eb), 64'(ROWS));
        for (int r = 0; r < ROWS; r++) begin
            if (sb + r < sr_a_log.size()) begin
                chk({tag, "_sr_addr"}, 64'(sr_a_log[sb + r]), 64'(r));
                chk({tag, "_sr_dout"}, 64'(sr_d_log[sb + r]), 64'(exp_row(0, r)));
            end
            if (eb + r < se_a_log.size()) begin
                chk({tag, "_se_addr"}, 64'(se_a_log[eb + r]), 64'(r));
                chk({tag, "_se_dout"}, 64'(se_d_log[eb + r]), 64'(exp_row(1, r)));
            end
        end
        chk({tag, "_idle_zero"}, 64'(idle_viol - iv), 64'd0);
        chk({tag, "_rw_overlap"}, 64'(both_viol - bv), 64'd0);
        chk({tag, "_err"}, 64'(err), PAD ? 64'(half_err(0) | half_err(1)) : 64'd0);
    endtask

    initial begin
        int sb, eb;
        tv[0] = '{0, 32'h89AB_CDEF, 32'h0000_0012, 40'h12_89AB_CDEF, 1'b0};
        tv[1] = '{1, 32'h89AB_CDEF, 32'hFFFF_FF12, 40'h12_89AB_CDEF, 1'b0};
        tv[2] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h00_000F_FFFF, 1'b1};
        tv[3] = '{2, 32'h1234_5678, 32'h0000_0000, 40'h00_0004_5678, 1'b1};
        tv[4] = '{2, 32'h000A_BCDE, 32'h0000_0000, 40'h00_000A_BCDE, 1'b0};
        tv[5] = '{1, 32'h0000_0000, 32'h0000_00FF, 40'hFF_0000_0000, 1'b0};

        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 64'(in_ready), 64'd0);

        // Back-to-back stream of distinct words.
        for (int i = 0; i < NW; i++) stim[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
        run_full(1'b0, -1, "seq");

        // Table vectors: the same word pair placed in one row of both halves.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NW; i++) stim[i] = '0;
            stim[tv[k].row * WPR]          = tv[k].w0;
            stim[tv[k].row * WPR + 1]      = tv[k].w1;
            stim[HW + tv[k].row * WPR]     = tv[k].w0;
            stim[HW + tv[k].row * WPR + 1] = tv[k].w1;
            sb = sr_d_log.size();
            eb = se_d_log.size();
            run_full(1'b0, -1, "tv");
            if (sb + tv[k].row < sr_d_log.size())
                chk("tv_sr_row", 64'(sr_d_log[sb + tv[k].row]), 64'(tv[k].dout));
            if (eb + tv[k].row < se_d_log.size())
                chk("tv_se_row", 64'(se_d_log[eb + tv[k].row]), 64'(tv[k].dout));
            chk("tv_err", 64'(err), PAD ? 64'(tv[k].perr) : 64'd0);
        end

        // Random data with random in_valid gaps.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NW; i++) stim[i] = $urandom;
            run_full(1'b1, -1, "rnd");
        end

        // Reset after five words, then a clean reload.
        for (int i = 0; i < NW; i++) stim[i] = 32'hFFFF_FFFF;
        feed(5, 1'b0, -1);
        rst_b = 1'b0;
        @(posedge clk); #1;
        check_zero("midreset");
        rst_b = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) stim[i] = $urandom & 32'h0F0F_0F0F;
        run_full(1'b0, -1, "reload");

        // start pulsed during LOAD_SE must not restart the load.
        for (int i = 0; i < NW; i++) stim[i] = $urandom;
        run_full(1'b1, 8, "poke");

        // in_valid while IDLE is never accepted.
        sb = sr_a_log.size();
        eb = se_a_log.size();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            chk("idle_valid_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid_sr", 64'(sr_a_log.size() - sb), 64'd0);
        chk("idle_valid_se", 64'(se_a_log.size() - eb), 64'd0);
        chk("idle_valid_done", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
